// File: rtl/digit_scan_controller.sv
// Scans the calculator digit buffer out to the VGA text renderer, one digit per
// valid/ready transfer, paced by a free-running clock-enable prescaler.
module digit_scan_controller #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned DIV        = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [DIGIT_W-1:0] wr_digit,
  input  logic [IDX_W-1:0]   len,
  input  logic               start,
  output logic               busy,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [IDX_W-1:0]   dig_idx,
  output logic [DIGIT_W-1:0] dig_value,
  output logic               frame_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    PRESENT   = 2'd2
  } state_e;

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic [IDX_W-1:0]   last_q,       last_d;
  logic               busy_q,       busy_d;
  logic               dig_valid_q,  dig_valid_d;
  logic [IDX_W-1:0]   dig_idx_q,    dig_idx_d;
  logic [DIGIT_W-1:0] dig_value_q,  dig_value_d;
  logic               frame_done_q, frame_done_d;
  logic [DIGIT_W-1:0] mem_q [NUM_DIGITS];
  logic [DIGIT_W-1:0] mem_d [NUM_DIGITS];

  logic               tick_c;
  logic [DIGIT_W-1:0] rd_digit_c;
  logic [IDX_W-1:0]   last_clamp_c;

  // Prescaler: ticks on the last count of each DIV-cycle period, never gated
  always_comb begin
    tick_c = (cnt_q == CNT_MAX);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // Buffer update; clr overrides a same-cycle write, out-of-range indices match nothing
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) mem_d[i] = '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (wr_idx == IDX_W'(i)) mem_d[i] = wr_digit;
      end
    end
  end

  // Read mux at the scan index and clamp of len to the buffer size
  always_comb begin
    rd_digit_c   = '0;
    last_clamp_c = LAST_MAX;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) rd_digit_c = mem_q[i];
      if (len == IDX_W'(i))   last_clamp_c = len;
    end
  end

  // Scan sequencer
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    busy_d       = busy_q;
    dig_valid_d  = dig_valid_q;
    dig_idx_d    = dig_idx_q;
    dig_value_d  = dig_value_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          last_d  = last_clamp_c;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick_c) begin
          dig_idx_d   = idx_q;
          dig_value_d = rd_digit_c;
          dig_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (dig_ready) begin
          dig_valid_d = 1'b0;
          if (idx_q == last_q) begin
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = WAIT_TICK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      last_q       <= '0;
      busy_q       <= 1'b0;
      dig_valid_q  <= 1'b0;
      dig_idx_q    <= '0;
      dig_value_q  <= '0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      dig_valid_q  <= dig_valid_d;
      dig_idx_q    <= dig_idx_d;
      dig_value_q  <= dig_value_d;
      frame_done_q <= frame_done_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign busy       = busy_q;
  assign dig_valid  = dig_valid_q;
  assign dig_idx    = dig_idx_q;
  assign dig_value  = dig_value_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Bench for digit_scan_controller: an 8-digit and a 4-digit instance share stimulus
// and are compared every cycle against a transfer-level reference model.
module tb_digit_scan_controller;

  localparam int unsigned DIV = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, wr_en = 1'b0, start = 1'b0, dig_ready = 1'b0;
  logic [2:0] wr_idx = '0, len = '0;
  logic [3:0] wr_digit = '0;

  logic       busy_a, dig_valid_a, frame_done_a, busy_b, dig_valid_b, frame_done_b;
  logic [2:0] dig_idx_a, dig_idx_b;
  logic [3:0] dig_value_a, dig_value_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  digit_scan_controller #(.NUM_DIGITS(8), .IDX_W(3), .DIGIT_W(4), .DIV(DIV)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_digit(wr_digit), .len(len), .start(start), .busy(busy_a),
    .dig_valid(dig_valid_a), .dig_ready(dig_ready), .dig_idx(dig_idx_a),
    .dig_value(dig_value_a), .frame_done(frame_done_a)
  );

  digit_scan_controller #(.NUM_DIGITS(4), .IDX_W(3), .DIGIT_W(4), .DIV(DIV)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_digit(wr_digit), .len(len), .start(start), .busy(busy_b),
    .dig_valid(dig_valid_b), .dig_ready(dig_ready), .dig_idx(dig_idx_b),
    .dig_value(dig_value_b), .frame_done(frame_done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one frame = request, then for each index wait for a tick,
  // present the buffer contents, hold until accepted.
  int unsigned n_dig [2] = '{8, 4};
  logic [3:0]  m_mem [2][8];
  bit          m_busy [2], m_valid [2], m_done [2];
  int unsigned m_idx [2], m_nxt [2], m_last [2];
  logic [3:0]  m_val [2];
  int unsigned cyc;
  bit          m_tick, m_done_n;

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 0; m_valid[j] = 0; m_done[j] = 0;
      m_idx[j] = 0; m_nxt[j] = 0; m_last[j] = 0; m_val[j] = '0;
      for (int i = 0; i < 8; i++) m_mem[j][i] = '0;
    end
    cyc = 0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_tick = ((cyc % DIV) == DIV - 1);
      for (int j = 0; j < 2; j++) begin
        m_done_n = 1'b0;
        if (!m_busy[j]) begin
          if (start) begin
            m_busy[j] = 1;
            m_last[j] = (int'(len) < n_dig[j]) ? int'(len) : n_dig[j] - 1;
            m_nxt[j]  = 0;
          end
        end else if (!m_valid[j]) begin
          if (m_tick) begin
            m_valid[j] = 1;
            m_idx[j]   = m_nxt[j];
            m_val[j]   = m_mem[j][m_nxt[j]];
          end
        end else if (dig_ready) begin
          m_valid[j] = 0;
          if (m_idx[j] == m_last[j]) begin
            m_busy[j] = 0;
            m_done_n  = 1'b1;
          end else begin
            m_nxt[j] = m_idx[j] + 1;
          end
        end
        m_done[j] = m_done_n;
        if (clr) begin
          for (int i = 0; i < 8; i++) m_mem[j][i] = '0;
        end else if (wr_en && int'(wr_idx) < n_dig[j]) begin
          m_mem[j][wr_idx] = wr_digit;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("a_busy",  32'(busy_a),       32'(m_busy[0]));
      check_eq("a_valid", 32'(dig_valid_a),  32'(m_valid[0]));
      check_eq("a_idx",   32'(dig_idx_a),    m_idx[0]);
      check_eq("a_value", 32'(dig_value_a),  32'(m_val[0]));
      check_eq("a_done",  32'(frame_done_a), 32'(m_done[0]));
      check_eq("b_busy",  32'(busy_b),       32'(m_busy[1]));
      check_eq("b_valid", 32'(dig_valid_b),  32'(m_valid[1]));
      check_eq("b_idx",   32'(dig_idx_b),    m_idx[1]);
      check_eq("b_value", 32'(dig_value_b),  32'(m_val[1]));
      check_eq("b_done",  32'(frame_done_b), 32'(m_done[1]));
    end
  end

  // Transfer monitor for scenario-level checks
  int         hs_cnt_a, hs_sum_a, done_cnt_a, hs_last_a, hs_cnt_b, done_cnt_b, hs_last_b;
  logic [3:0] hs_val_a [8];

  always @(negedge clk) begin
    if (rst_n) begin
      if (dig_valid_a && dig_ready) begin
        hs_cnt_a++; hs_sum_a += int'(dig_value_a);
        hs_val_a[dig_idx_a] = dig_value_a; hs_last_a = int'(dig_idx_a);
      end
      if (dig_valid_b && dig_ready) begin
        hs_cnt_b++; hs_last_b = int'(dig_idx_b);
      end
      if (frame_done_a) done_cnt_a++;
      if (frame_done_b) done_cnt_b++;
    end
  end

  task automatic clear_mon();
    hs_cnt_a = 0; hs_sum_a = 0; done_cnt_a = 0; hs_last_a = -1;
    hs_cnt_b = 0; done_cnt_b = 0; hs_last_b = -1;
    for (int i = 0; i < 8; i++) hs_val_a[i] = 4'hF;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    clr = 0; wr_en = 0; start = 0; dig_ready = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_digit(input logic [2:0] i, input logic [3:0] v);
    wr_en = 1; wr_idx = i; wr_digit = v;
    step();
    wr_en = 0;
  endtask

  task automatic wait_done(input int rdy_pct, input bit restart);
    int n;
    n = 0;
    while (!frame_done_a && n < 300) begin
      dig_ready = ($urandom_range(99) < rdy_pct);
      start = (restart && n == 3);
      step();
      n++;
    end
    check_eq("frame_timeout", 32'(n < 300), 32'd1);
    start = 0; dig_ready = 0;
    step();
  endtask

  task automatic run_frame(input logic [2:0] l, input int rdy_pct, input bit restart);
    clear_mon();
    start = 1; len = l;
    step();
    start = 0;
    wait_done(rdy_pct, restart);
  endtask

  task automatic wait_valid_idx(input logic [2:0] want);
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (dig_valid_a && dig_idx_a == want) begin
        ok = 1;
        break;
      end
      step();
    end
    check_eq("wait_valid", 32'(ok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    model_reset();
    chk_en = 1'b1;
    do_reset();

    // Full frame of 9s, always ready
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'd9);
    run_frame(3'd7, 100, 0);
    check_eq("t2_count", 32'(hs_cnt_a), 32'd8);
    check_eq("t2_sum",   32'(hs_sum_a), 32'd72);
    check_eq("t2_done",  32'(done_cnt_a), 32'd1);
    check_eq("t2_last",  32'(hs_last_a), 32'd7);

    // Async reset while idx 3 is presented
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i + 1));
    clear_mon();
    dig_ready = 1; start = 1; len = 3'd7;
    step();
    start = 0;
    wait_valid_idx(3'd3);
    dig_ready = 0;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t1_valid", 32'(dig_valid_a), 32'd0);
    check_eq("t1_busy",  32'(busy_a), 32'd0);
    check_eq("t1_idx",   32'(dig_idx_a), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_frame(3'd7, 100, 0);
    check_eq("t1_count", 32'(hs_cnt_a), 32'd8);
    check_eq("t1_zero",  32'(hs_sum_a), 32'd0);

    // Stall on idx 2 and overwrite the presented digit
    do_reset();
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i + 2));
    clear_mon();
    dig_ready = 1; start = 1; len = 3'd7;
    step();
    start = 0;
    wait_valid_idx(3'd2);
    dig_ready = 0;
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_valid", 32'(dig_valid_a), 32'd1);
      check_eq("t3_idx",   32'(dig_idx_a), 32'd2);
      check_eq("t3_value", 32'(dig_value_a), 32'd4);
      wr_en = (k == 1); wr_idx = 3'd2; wr_digit = 4'd7;
      step();
    end
    wr_en = 0;
    check_eq("t4_held", 32'(dig_value_a), 32'd4);
    dig_ready = 1;
    step();
    check_eq("t3_drop", 32'(dig_valid_a), 32'd0);
    wait_valid_idx(3'd3);
    wait_done(100, 0);
    run_frame(3'd7, 100, 0);
    check_eq("t4_new", 32'(hs_val_a[2]), 32'd7);

    // clr beats a same-cycle write; single-digit frame
    for (int i = 0; i < 8; i++) write_digit(3'(i), 4'd6);
    clr = 1; wr_en = 1; wr_idx = 3'd1; wr_digit = 4'd5;
    step();
    clr = 0; wr_en = 0;
    run_frame(3'd0, 100, 0);
    check_eq("t5_count", 32'(hs_cnt_a), 32'd1);
    check_eq("t5_idx",   32'(hs_last_a), 32'd0);
    check_eq("t5_done",  32'(done_cnt_a), 32'd1);
    run_frame(3'd1, 100, 0);
    check_eq("t5_mem1",  32'(hs_val_a[1]), 32'd0);

    // Restart while busy is ignored; 4-digit instance clamps len
    do_reset();
    run_frame(3'd7, 60, 1);
    check_eq("t6_done_a",  32'(done_cnt_a), 32'd1);
    check_eq("t6_count_a", 32'(hs_cnt_a), 32'd8);
    check_eq("t6_count_b", 32'(hs_cnt_b), 32'd4);
    check_eq("t6_last_b",  32'(hs_last_b), 32'd3);
    check_eq("t6_done_b",  32'(done_cnt_b), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        clr       = ($urandom_range(99) < 3);
        wr_en     = ($urandom_range(99) < 30);
        wr_idx    = 3'($urandom_range(7));
        wr_digit  = 4'($urandom_range(15));
        start     = ($urandom_range(99) < 10);
        len       = 3'($urandom_range(7));
        dig_ready = ($urandom_range(99) < 50);
        step();
      end
    end
    clr = 0; wr_en = 0; start = 0; dig_ready = 0;
    step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
